// File: rtl/disp_scan_hms.sv
// rtl/disp_scan_hms.sv - 6-digit multiplexed 7-segment HH:MM:SS display scanner
// Frame-latched BCD snapshot, blank-first digit slots, set-mode digit blink and colon blink.
module disp_scan_hms #(
  parameter int SCAN_DIV = 1000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic       disp_clock,
  input  logic       reset,
  input  logic       enable_1hz,
  input  logic [1:0] set_mode,
  input  logic [2:0] h_msd,
  input  logic [3:0] h_lsd,
  input  logic [2:0] m_msd,
  input  logic [3:0] m_lsd,
  input  logic [2:0] s_msd,
  input  logic [3:0] s_lsd,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] r_div_cnt;
  logic [2:0]    r_dig_idx;
  logic [2:0]    r_snap_h_msd;
  logic [3:0]    r_snap_h_lsd;
  logic [2:0]    r_snap_m_msd;
  logic [3:0]    r_snap_m_lsd;
  logic [2:0]    r_snap_s_msd;
  logic [3:0]    r_snap_s_lsd;
  logic          r_blink_phase;
  logic [5:0]    r_an_n;
  logic [6:0]    r_seg_n;
  logic          r_dp_n;

  logic          w_tick;
  logic          w_frame_end;
  logic          w_blank;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blink_sup;
  logic          w_lz_sup;
  logic [5:0]    w_lit_an;
  logic [5:0]    w_an_next;
  logic [6:0]    w_seg_next;
  logic          w_dp_next;

  assign w_tick      = (r_div_cnt == DW'(SCAN_DIV - 1));
  assign w_frame_end = w_tick && (r_dig_idx == 3'd5);
  assign w_blank     = (r_div_cnt == '0);

  always_comb begin
    w_digit = 4'd0;
    case (r_dig_idx)
      3'd0:    w_digit = r_snap_s_lsd;
      3'd1:    w_digit = {1'b0, r_snap_s_msd};
      3'd2:    w_digit = r_snap_m_lsd;
      3'd3:    w_digit = {1'b0, r_snap_m_msd};
      3'd4:    w_digit = r_snap_h_lsd;
      3'd5:    w_digit = {1'b0, r_snap_h_msd};
      default: w_digit = 4'd0;
    endcase
  end

  // Segment patterns are {g,f,e,d,c,b,a}, active low; non-BCD values show a dash.
  always_comb begin
    w_seg_dec = 7'b0111111;
    case (w_digit)
      4'd0:    w_seg_dec = 7'b1000000;
      4'd1:    w_seg_dec = 7'b1111001;
      4'd2:    w_seg_dec = 7'b0100100;
      4'd3:    w_seg_dec = 7'b0110000;
      4'd4:    w_seg_dec = 7'b0011001;
      4'd5:    w_seg_dec = 7'b0010010;
      4'd6:    w_seg_dec = 7'b0000010;
      4'd7:    w_seg_dec = 7'b1111000;
      4'd8:    w_seg_dec = 7'b0000000;
      4'd9:    w_seg_dec = 7'b0010000;
      default: w_seg_dec = 7'b0111111;
    endcase
  end

  always_comb begin
    w_blink_sup = 1'b0;
    case (set_mode)
      2'd1:    w_blink_sup = (r_dig_idx == 3'd4) || (r_dig_idx == 3'd5);
      2'd2:    w_blink_sup = (r_dig_idx == 3'd2) || (r_dig_idx == 3'd3);
      2'd3:    w_blink_sup = (r_dig_idx == 3'd0) || (r_dig_idx == 3'd1);
      default: w_blink_sup = 1'b0;
    endcase
    w_blink_sup = w_blink_sup && r_blink_phase;
  end

  assign w_lz_sup = LZ_BLANK && (r_dig_idx == 3'd5) && (r_snap_h_msd == 3'd0);
  assign w_lit_an = ~(6'b000001 << r_dig_idx);

  // Suppression only gates the anode; segments keep decoding so the bus stays predictable.
  assign w_an_next  = (w_blank || w_blink_sup || w_lz_sup) ? 6'h3F : w_lit_an;
  assign w_seg_next = w_blank ? 7'h7F : w_seg_dec;
  assign w_dp_next  = w_blank ? 1'b1 :
                      ~(((r_dig_idx == 3'd2) || (r_dig_idx == 3'd4)) && !r_blink_phase);

  always_ff @(posedge disp_clock or posedge reset) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_dig_idx     <= 3'd0;
      r_snap_h_msd  <= 3'd0;
      r_snap_h_lsd  <= 4'd0;
      r_snap_m_msd  <= 3'd0;
      r_snap_m_lsd  <= 4'd0;
      r_snap_s_msd  <= 3'd0;
      r_snap_s_lsd  <= 4'd0;
      r_blink_phase <= 1'b0;
      r_an_n        <= 6'h3F;
      r_seg_n       <= 7'h7F;
      r_dp_n        <= 1'b1;
    end else begin
      r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
      if (w_tick) begin
        r_dig_idx <= (r_dig_idx == 3'd5) ? 3'd0 : r_dig_idx + 3'd1;
      end
      if (w_frame_end) begin
        r_snap_h_msd <= h_msd;
        r_snap_h_lsd <= h_lsd;
        r_snap_m_msd <= m_msd;
        r_snap_m_lsd <= m_lsd;
        r_snap_s_msd <= s_msd;
        r_snap_s_lsd <= s_lsd;
      end
      if (enable_1hz) begin
        r_blink_phase <= ~r_blink_phase;
      end
      r_an_n  <= w_an_next;
      r_seg_n <= w_seg_next;
      r_dp_n  <= w_dp_next;
    end
  end

  assign an_n  = r_an_n;
  assign seg_n = r_seg_n;
  assign dp_n  = r_dp_n;

endmodule

// File: tb/tb_disp_scan_hms.sv
// tb/tb_disp_scan_hms.sv - scoreboard bench for disp_scan_hms (SCAN_DIV=4, LZ_BLANK=1 and 0)
module tb_disp_scan_hms;

  logic       disp_clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable_1hz = 1'b0;
  logic [1:0] set_mode = 2'd0;
  logic [2:0] h_msd = 3'd0;
  logic [3:0] h_lsd = 4'd0;
  logic [2:0] m_msd = 3'd0;
  logic [3:0] m_lsd = 4'd0;
  logic [2:0] s_msd = 3'd0;
  logic [3:0] s_lsd = 4'd0;
  logic [5:0] an_n, an_n2;
  logic [6:0] seg_n, seg_n2;
  logic       dp_n, dp_n2;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0] an;
    logic [5:0] an2;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb[$];

  int         m_div;
  int         m_idx;
  logic       m_phase;
  logic [3:0] m_snap [6];

  disp_scan_hms #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut (
    .disp_clock(disp_clock), .reset(reset), .enable_1hz(enable_1hz), .set_mode(set_mode),
    .h_msd(h_msd), .h_lsd(h_lsd), .m_msd(m_msd), .m_lsd(m_lsd), .s_msd(s_msd), .s_lsd(s_lsd),
    .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n)
  );

  disp_scan_hms #(.SCAN_DIV(4), .LZ_BLANK(1'b0)) dut_nz (
    .disp_clock(disp_clock), .reset(reset), .enable_1hz(enable_1hz), .set_mode(set_mode),
    .h_msd(h_msd), .h_lsd(h_lsd), .m_msd(m_msd), .m_lsd(m_lsd), .s_msd(s_msd), .s_lsd(s_lsd),
    .an_n(an_n2), .seg_n(seg_n2), .dp_n(dp_n2)
  );

  always #5 disp_clock = ~disp_clock;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: dec7 = 7'b1000000;
      4'd1: dec7 = 7'b1111001;
      4'd2: dec7 = 7'b0100100;
      4'd3: dec7 = 7'b0110000;
      4'd4: dec7 = 7'b0011001;
      4'd5: dec7 = 7'b0010010;
      4'd6: dec7 = 7'b0000010;
      4'd7: dec7 = 7'b1111000;
      4'd8: dec7 = 7'b0000000;
      4'd9: dec7 = 7'b0010000;
      default: dec7 = 7'b0111111;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    logic [5:0] lit;
    logic sup_blink, sup_lz;
    e = '{an: 6'h3F, an2: 6'h3F, seg: 7'h7F, dp: 1'b1};
    if (m_div != 0) begin
      lit = 6'h3F;
      lit[m_idx] = 1'b0;
      sup_blink = m_phase && (set_mode != 2'd0) && ((m_idx / 2) == (3 - int'(set_mode)));
      sup_lz = (m_idx == 5) && (m_snap[5] == 4'd0);
      e.seg = dec7(m_snap[m_idx]);
      e.an  = (sup_blink || sup_lz) ? 6'h3F : lit;
      e.an2 = sup_blink ? 6'h3F : lit;
      e.dp  = !(((m_idx == 2) || (m_idx == 4)) && !m_phase);
    end
    return e;
  endfunction

  task automatic model_reset();
    m_div = 0;
    m_idx = 0;
    m_phase = 1'b0;
    for (int i = 0; i < 6; i++) m_snap[i] = 4'd0;
    sb.delete();
  endtask

  // One clock: push the model's prediction, advance the model, then sample point #1 after the edge.
  task automatic step();
    sb.push_back(model_out());
    if (m_div == 3 && m_idx == 5) begin
      m_snap[0] = s_lsd;
      m_snap[1] = {1'b0, s_msd};
      m_snap[2] = m_lsd;
      m_snap[3] = {1'b0, m_msd};
      m_snap[4] = h_lsd;
      m_snap[5] = {1'b0, h_msd};
    end
    if (enable_1hz) m_phase = !m_phase;
    if (m_div == 3) begin
      m_div = 0;
      m_idx = (m_idx == 5) ? 0 : m_idx + 1;
    end else begin
      m_div = m_div + 1;
    end
    @(posedge disp_clock);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (an_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got an=%h seg=%b dp=%b exp an=3f seg=1111111 dp=1", an_n, seg_n, dp_n);
    end
    @(posedge disp_clock);
    @(posedge disp_clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic test_async_reset();
    exp_t e;
    h_msd = 3'd1; h_lsd = 4'd2; m_msd = 3'd3; m_lsd = 4'd4; s_msd = 3'd5; s_lsd = 4'd6;
    for (int k = 1; k <= 38; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_pre_reset k=%0d got an=%h seg=%b dp=%b an2=%h exp an=%h seg=%b dp=%b an2=%h",
                 k, an_n, seg_n, dp_n, an_n2, e.an, e.seg, e.dp, e.an2);
      end
    end
    #3 reset = 1'b1;
    #1;
    checks++;
    if (an_n !== 6'h3F || seg_n !== 7'h7F || dp_n !== 1'b1 || an_n2 !== 6'h3F || seg_n2 !== 7'h7F) begin
      errors++;
      $display("FAIL async_reset got an=%h seg=%b dp=%b an2=%h seg2=%b exp an=3f seg=1111111 dp=1",
               an_n, seg_n, dp_n, an_n2, seg_n2);
    end
    @(posedge disp_clock);
    #1 reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 24; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_post_reset k=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b",
                 k, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
      end
      if (k == 1 || k == 2) begin
        checks++;
        if ((k == 1 && an_n !== 6'h3F) || (k == 2 && (an_n !== 6'h3E || seg_n !== 7'b1000000))) begin
          errors++;
          $display("FAIL first_slot0 k=%0d got an=%h seg=%b", k, an_n, seg_n);
        end
      end
    end
  endtask

  task automatic test_frames();
    exp_t e;
    for (int k = 1; k <= 48; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_frames k=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b",
                 k, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
      end
      if (k == 26 || k == 28) begin
        checks++;
        if (an_n !== 6'h3E || seg_n !== 7'b0000010) begin
          errors++;
          $display("FAIL frame_slot0 k=%0d got an=%h seg=%b exp an=3e seg=0000010", k, an_n, seg_n);
        end
      end
      if (k == 29 || k == 45) begin
        checks++;
        if (an_n !== 6'h3F || seg_n !== 7'h7F) begin
          errors++;
          $display("FAIL frame_blank k=%0d got an=%h seg=%b exp an=3f seg=1111111", k, an_n, seg_n);
        end
      end
      if (k == 46) begin
        checks++;
        if (an_n !== 6'h1F || seg_n !== 7'b1111001) begin
          errors++;
          $display("FAIL frame_slot5 got an=%h seg=%b exp an=1f seg=1111001", an_n, seg_n);
        end
      end
    end
  endtask

  task automatic test_midframe_change();
    exp_t e;
    for (int k = 1; k <= 48; k++) begin
      if (k == 11) s_lsd = 4'd7;
      step();
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_midframe k=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b",
                 k, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
      end
      if (k == 26) begin
        checks++;
        if (seg_n !== 7'b1111000) begin
          errors++;
          $display("FAIL next_frame_s_lsd got seg=%b exp seg=1111000", seg_n);
        end
      end
    end
  endtask

  task automatic test_dash();
    exp_t e;
    m_lsd = 4'hB;
    for (int k = 1; k <= 48; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_dash k=%0d got an=%h seg=%b dp=%b exp an=%h seg=%b dp=%b",
                 k, an_n, seg_n, dp_n, e.an, e.seg, e.dp);
      end
      if (k == 10 || k == 34) begin
        checks++;
        if (an_n !== 6'h3B || dp_n !== 1'b0 ||
            seg_n !== ((k == 10) ? 7'b0011001 : 7'b0111111)) begin
          errors++;
          $display("FAIL dash_slot2 k=%0d got an=%h seg=%b dp=%b", k, an_n, seg_n, dp_n);
        end
      end
    end
  endtask

  task automatic test_blink();
    exp_t e;
    set_mode = 2'd1;
    for (int k = 1; k <= 72; k++) begin
      enable_1hz = (k == 1 || k == 25 || k == 52);
      step();
      enable_1hz = 1'b0;
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_blink k=%0d got an=%h seg=%b dp=%b an2=%h exp an=%h seg=%b dp=%b an2=%h",
                 k, an_n, seg_n, dp_n, an_n2, e.an, e.seg, e.dp, e.an2);
      end
      if (k >= 2 && k <= 24) begin
        checks++;
        if (an_n[5:4] !== 2'b11 || an_n2[5:4] !== 2'b11 || dp_n !== 1'b1) begin
          errors++;
          $display("FAIL blink_off k=%0d got an=%h an2=%h dp=%b", k, an_n, an_n2, dp_n);
        end
      end
      if (k == 34 || k == 42 || k == 46) begin
        checks++;
        if (an_n !== ((k == 46) ? 6'h1F : (k == 42) ? 6'h2F : 6'h3B) ||
            dp_n !== ((k == 46) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL blink_on k=%0d got an=%h dp=%b", k, an_n, dp_n);
        end
      end
    end
    set_mode = 2'd0;
  endtask

  task automatic test_lz();
    exp_t e;
    h_msd = 3'd0; h_lsd = 4'd7;
    for (int k = 1; k <= 48; k++) begin
      step();
      e = sb.pop_front();
      checks++;
      if ({an_n, seg_n, dp_n, an_n2, seg_n2, dp_n2} !== {e.an, e.seg, e.dp, e.an2, e.seg, e.dp}) begin
        errors++;
        $display("FAIL sb_lz k=%0d got an=%h seg=%b an2=%h seg2=%b exp an=%h seg=%b an2=%h",
                 k, an_n, seg_n, an_n2, seg_n2, e.an, e.seg, e.an2);
      end
      if (k > 24) begin
        checks++;
        if (an_n[5] !== 1'b1) begin
          errors++;
          $display("FAIL lz_blank k=%0d got an=%h exp an[5]=1", k, an_n);
        end
      end
      if (k == 46) begin
        checks++;
        if (an_n2 !== 6'h1F || seg_n2 !== 7'b1000000) begin
          errors++;
          $display("FAIL lz_off_slot5 got an2=%h seg2=%b exp an2=1f seg2=1000000", an_n2, seg_n2);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_async_reset();
    test_frames();
    test_midframe_change();
    test_dash();
    test_blink();
    test_lz();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
